spmv_op_issuer: RTL and testbench
=================================

# spmv_op_issuer

- Host-side head of the SpMV PE op ring.
- Accepts 64-bit ops from the host over a valid/ready port and buffers them in a small FIFO.
- Drives them one per cycle onto the ring's `op` input of PE 0, and NOPs (all zeros) when it has nothing to issue.
- After issuing a STEADY op it fences: no further ops are issued until the `busy` chain returning from the last PE confirms every PE has gone idle.

## Interface
Parameters:
- `NUM_PE`, default 8: PEs on the ring, 1..250; sets drain hold-off.
- `DEPTH`, default 4: command FIFO depth, power of two, ≥2.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: host op valid.
- `cmd_op`, input, 64: host op. Fields:
  - `[6:0]` opcode: NOP=0, RST=1, STEADY=2, LD=3.
  - `[10:7]` PE id.
  - `[11]` broadcast.
  - `[15:12]` register index.
  - `[63:16]` 48-bit data.
- `cmd_ready`, output, 1: FIFO can accept; a transfer occurs on `cmd_valid & cmd_ready` at a rising edge.
- `abort`, input, 1: flush FIFO, cancel any fence.
- `op_out`, output, 64: registered op to PE 0; 0 = NOP.
- `busy_in`, input, 1: `busy` output of the last PE on the chain.
- `drain_done`, output, 1: one-cycle pulse when a fence completes.
- `ring_idle`, output, 1: FIFO empty, state ISSUE, and `busy_in` low.

## Operation
- **FIFO**
  - `DEPTH` entries, with read/write pointers of log2(DEPTH) bits that wrap modulo `DEPTH`.
  - A count of log2(DEPTH)+1 bits.
  - `cmd_ready = (count != DEPTH)`, combinational from registered count.
  - Push and pop in the same cycle: count unchanged. Push is never accepted when full; pop never occurs when empty.
- **State machine**: ISSUE, HOLDOFF, DRAIN.
  - **ISSUE**
    - FIFO non-empty: pop the head and register it to `op_out`.
    - FIFO empty: `op_out <= 0`.
    - If the popped opcode == STEADY: load `holdoff_cnt <= NUM_PE+3` and go to HOLDOFF. The popped STEADY op is itself issued.
  - **HOLDOFF**
    - `op_out <= 0`; `holdoff_cnt` decrements each cycle.
    - Go to DRAIN on the edge where the count goes 1→0.
    - `busy_in` is ignored here, because the STEADY status has not yet propagated back.
  - **DRAIN**
    - `op_out <= 0`.
    - When sampled `busy_in == 0`: assert `drain_done` for the next cycle and return to ISSUE.
- FIFO pushes continue in HOLDOFF and DRAIN; only pops stop.
- RST, LD, NOP and unknown opcodes are issued verbatim with no fence.
- **`abort`** (sampled synchronously, highest priority):
  - Empties the FIFO (pointers and count to 0) and forces state ISSUE.
  - `op_out <= 0` and `drain_done` stays 0 that cycle.
  - A push presented in the same cycle is dropped.
- `holdoff_cnt` is 8 bits.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n` low):
  - `op_out` = 0, `drain_done` = 0, state ISSUE, FIFO empty, `holdoff_cnt` = 0.
  - `cmd_ready` = 1 and `ring_idle` = `!busy_in`.
- **Accept-to-issue latency**: an op accepted at edge E with an empty FIFO in ISSUE appears on `op_out` after edge E+1. Back-to-back accepts issue on consecutive cycles, with throughput 1 op/cycle.
- **Fence**: STEADY on `op_out` after edge S.
  - HOLDOFF covers edges S+1..S+NUM_PE+3, with `op_out` = 0 throughout.
  - DRAIN begins after edge S+NUM_PE+3. With `busy_in` already low, `drain_done` pulses after edge S+NUM_PE+4, and the next queued op issues at edge S+NUM_PE+5.
- `ring_idle` and `cmd_ready` are combinational from registered state plus `busy_in`, so there is no added latency.
- **Reset mid-fence**: returns to ISSUE with the FIFO empty; no `drain_done` is generated.

## Test plan
- **Reset**: `rst_n` low for 3 cycles mid-traffic.
  - Response: `op_out` = 0, `cmd_ready` = 1, `drain_done` = 0 immediately (asynchronous, without waiting for a clock edge).
- **Streaming**: push LD ops 0x…0003, 0x…1003, 0x…2003 on consecutive edges with `busy_in` = 0.
  - Response: they appear on `op_out` on 3 consecutive cycles starting 2 edges after the first accept, followed by 0.
- **Full FIFO**: `NUM_PE` = 8, `DEPTH` = 4; push STEADY then 5 LD ops.
  - Response: `cmd_ready` falls once 4 entries are held; the 5th LD is held by the host.
  - No LD reaches `op_out` during the 11 HOLDOFF cycles.
- **Fence with busy**: STEADY issued, `busy_in` high for 20 cycles after HOLDOFF ends.
  - Response: `op_out` stays 0 until `busy_in` falls; `drain_done` is a single-cycle pulse; the queued LD issues 1 cycle after the pulse.
- **Busy glitch in HOLDOFF**: `busy_in` low throughout HOLDOFF.
  - Response: `drain_done` still no earlier than S+NUM_PE+4.
- **Abort mid-DRAIN** with 3 queued ops and a simultaneous push.
  - Response: FIFO empty, state ISSUE, no `drain_done`, none of the 4 ops ever appears on `op_out`.

Source files
------------

// File: rtl/spmv_op_issuer_if.sv
// Host command port of the SpMV op issuer: a valid/ready handshake carrying one 64-bit PE op.
// master = host (drives cmd_valid, cmd_op; samples cmd_ready), slave = issuer (drives cmd_ready).
interface spmv_op_issuer_if;
    logic        cmd_valid;
    logic [63:0] cmd_op;
    logic        cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready
    );
endinterface

// File: rtl/spmv_op_issuer.sv
// Host-side head of the SpMV PE op ring: buffers host ops in a FIFO, issues one per cycle to PE 0,
// and fences after each STEADY op until the returning busy chain shows every PE idle.
// Ports: clk, rst_n (async, active low); cmd (slave: cmd_valid, cmd_op, cmd_ready); abort (sync flush);
// op_out (registered op to PE 0, 0 = NOP); busy_in (busy from last PE); drain_done (fence-complete pulse);
// ring_idle (FIFO empty, issuing, ring not busy).
module spmv_op_issuer #(
    parameter int NUM_PE = 8,
    parameter int DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    spmv_op_issuer_if.slave cmd,
    input  logic            abort,
    output logic [63:0]     op_out,
    input  logic            busy_in,
    output logic            drain_done,
    output logic            ring_idle
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [7:0]    HOLD_LOAD  = 8'(NUM_PE + 3);
    localparam logic [6:0]    OPC_STEADY = 7'd2;

    localparam logic [1:0] ST_ISSUE   = 2'd0;
    localparam logic [1:0] ST_HOLDOFF = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic [63:0]   op_q, op_d;
    logic          drain_q, drain_d;

    logic          empty;
    logic          push;
    logic          pop;
    logic [63:0]   head;

    assign empty         = (count_q == '0);
    assign cmd.cmd_ready = (count_q != FULL_CNT);
    assign head          = mem_q[rd_ptr_q];

    // Abort wins over everything: a push offered alongside it is dropped.
    assign push = cmd.cmd_valid & cmd.cmd_ready & ~abort;
    assign pop  = (state_q == ST_ISSUE) & ~empty & ~abort;

    assign op_out     = op_q;
    assign drain_done = drain_q;
    assign ring_idle  = empty & (state_q == ST_ISSUE) & ~busy_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        hold_d   = hold_q;
        op_d     = '0;
        drain_d  = 1'b0;

        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = ST_ISSUE;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            unique case (state_q)
                ST_ISSUE: begin
                    if (pop) begin
                        op_d = head;
                        if (head[6:0] == OPC_STEADY) begin
                            hold_d  = HOLD_LOAD;
                            state_d = ST_HOLDOFF;
                        end
                    end
                end
                // busy_in is not trusted yet: STEADY status is still in flight.
                ST_HOLDOFF: begin
                    hold_d = hold_q - 8'd1;
                    if (hold_q <= 8'd1) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!busy_in) begin
                        drain_d = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
                default: begin
                    state_d = ST_ISSUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_ISSUE;
            hold_q   <= '0;
            op_q     <= '0;
            drain_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            op_q     <= op_d;
            drain_q  <= drain_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= cmd.cmd_op;
        end
    end

endmodule

// File: tb/tb_spmv_op_issuer.sv
// Self-checking bench for spmv_op_issuer: scoreboard of issued ops, fence timing,
// full FIFO, busy fence, abort in DRAIN, and asynchronous reset mid-fence.
module tb_spmv_op_issuer;

    localparam int NUM_PE = 8;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        abort = 1'b0;
    logic        busy_in = 1'b0;
    logic [63:0] op_out;
    logic        drain_done;
    logic        ring_idle;

    spmv_op_issuer_if cif ();

    spmv_op_issuer #(
        .NUM_PE(NUM_PE),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cif),
        .abort     (abort),
        .op_out    (op_out),
        .busy_in   (busy_in),
        .drain_done(drain_done),
        .ring_idle (ring_idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] exp_q[$];

    int st_cyc = 0;
    int dd_cyc = 0;
    int dd_cnt = 0;
    int first_after = -1;
    int last_iss = 0;
    int acc_cyc = 0;
    int flush_cnt = 0;
    int flush_seen = 0;
    bit fence_open = 1'b0;
    bit want_first = 1'b0;

    typedef struct {
        logic [63:0] op;
        bit          fence;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every non-NOP op must match the scoreboard and must not escape a fence.
    initial begin
        forever begin
            @(negedge clk);
            if (flush_cnt != flush_seen) begin
                flush_seen = flush_cnt;
                fence_open = 1'b0;
                want_first = 1'b0;
            end
            if (rst_n) begin
                if (drain_done) begin
                    dd_cyc = cyc;
                    dd_cnt++;
                    fence_open = 1'b0;
                    want_first = 1'b1;
                    first_after = -1;
                end
                if (op_out !== 64'h0) begin
                    chk("fence_hold", 64'(fence_open), 64'h0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_op", op_out, 64'h0);
                    end else begin
                        chk("sb_op", op_out, exp_q.pop_front());
                    end
                    last_iss = cyc;
                    if (want_first) begin
                        first_after = cyc;
                        want_first = 1'b0;
                    end
                    if (op_out[6:0] == 7'd2) begin
                        st_cyc = cyc;
                        fence_open = 1'b1;
                    end
                end
            end
        end
    end

    task automatic push(input logic [63:0] op, input bit expect_issue);
        int n = 0;
        while (!cif.cmd_ready && n < 300) begin
            step();
            n++;
        end
        if (!cif.cmd_ready) begin
            chk("push_timeout", 64'(cif.cmd_ready), 64'h1);
        end else begin
            cif.cmd_valid = 1'b1;
            cif.cmd_op    = op;
            if (expect_issue) exp_q.push_back(op);
            step();
            acc_cyc = cyc;
            cif.cmd_valid = 1'b0;
            cif.cmd_op    = '0;
        end
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        bit ok;
        ok = ring_idle && (exp_q.size() == 0) && (op_out == 64'h0);
        while (!ok && n < lim) begin
            step();
            n++;
            ok = ring_idle && (exp_q.size() == 0) && (op_out == 64'h0);
        end
        chk("idle_reached", 64'(ok), 64'h1);
        step();
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 500) begin
            step();
            n++;
        end
        chk("wait_cyc_to", 64'(cyc >= target), 64'h1);
    endtask

    logic [63:0] sv[3];
    logic [63:0] sx[6];
    logic [63:0] ld[5];
    int d0;
    int t0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = '0;

        vt[0] = '{64'hDEAD_BEEF_0001_0003, 1'b0};
        vt[1] = '{64'h0000_0000_0000_0881, 1'b0};
        vt[2] = '{64'h1234_5678_9ABC_0002, 1'b1};
        vt[3] = '{64'hFFFF_0000_0000_007F, 1'b0};
        vt[4] = '{64'h0000_0000_0001_0000, 1'b0};
        vt[5] = '{64'h0000_0000_00AA_0042, 1'b0};
        vt[6] = '{64'h0000_0000_0000_0F82, 1'b1};
        vt[7] = '{64'h0000_0000_0000_0005, 1'b0};

        sv[0] = 64'hA5A5_0000_0001_0003;
        sv[1] = 64'hA5A5_0000_0002_1003;
        sv[2] = 64'hA5A5_0000_0003_2003;
        sx[0] = 64'h0;
        sx[1] = 64'h0;
        sx[2] = sv[0];
        sx[3] = sv[1];
        sx[4] = sv[2];
        sx[5] = 64'h0;

        for (int i = 0; i < 5; i++) begin
            ld[i] = {48'h00C0_FFEE_0000 + 48'(i), 16'h0003};
        end

        // Reset state
        rst_n = 1'b0;
        #1;
        chk("rst_op_out", op_out, 64'h0);
        chk("rst_cmd_ready", 64'(cif.cmd_ready), 64'h1);
        chk("rst_drain_done", 64'(drain_done), 64'h0);
        chk("rst_ring_idle_lo", 64'(ring_idle), 64'h1);
        busy_in = 1'b1;
        #1;
        chk("rst_ring_idle_busy", 64'(ring_idle), 64'h0);
        busy_in = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Streaming: three LDs on consecutive edges
        for (int t = 0; t < 6; t++) begin
            step();
            chk("stream_op", op_out, sx[t]);
            if (t < 3) begin
                cif.cmd_valid = 1'b1;
                cif.cmd_op    = sv[t];
                exp_q.push_back(sv[t]);
            end else begin
                cif.cmd_valid = 1'b0;
                cif.cmd_op    = '0;
            end
        end
        wait_idle(50);

        // Opcode table: verbatim issue, 1-cycle latency, fence only on STEADY
        for (int i = 0; i < 8; i++) begin
            d0 = dd_cnt;
            push(vt[i].op, 1'b1);
            wait_idle(100);
            chk("vec_latency", 64'(last_iss - acc_cyc), 64'h1);
            if (vt[i].fence) begin
                chk("vec_dd_count", 64'(dd_cnt - d0), 64'h1);
                chk("vec_dd_latency", 64'(dd_cyc - st_cyc), 64'(NUM_PE + 4));
            end else begin
                chk("vec_no_dd", 64'(dd_cnt - d0), 64'h0);
            end
        end

        // Full FIFO behind a STEADY fence
        d0 = dd_cnt;
        push(64'h0000_0000_0000_0002, 1'b1);
        for (int i = 0; i < 4; i++) push(ld[i], 1'b1);
        chk("full_ready_low", 64'(cif.cmd_ready), 64'h0);
        push(ld[4], 1'b1);
        wait_idle(200);
        chk("full_dd_count", 64'(dd_cnt - d0), 64'h1);
        chk("full_dd_latency", 64'(dd_cyc - st_cyc), 64'(NUM_PE + 4));
        chk("full_next_issue", 64'(first_after - dd_cyc), 64'h1);

        // Fence held by busy for 20 cycles after HOLDOFF
        d0 = dd_cnt;
        busy_in = 1'b1;
        push(64'h0000_0000_0000_0002, 1'b1);
        push(ld[0], 1'b1);
        step();
        wait_cyc(st_cyc + NUM_PE + 3 + 20);
        chk("busy_no_dd", 64'(dd_cnt - d0), 64'h0);
        chk("busy_not_idle", 64'(ring_idle), 64'h0);
        chk("busy_op_zero", op_out, 64'h0);
        busy_in = 1'b0;
        t0 = cyc;
        wait_idle(100);
        chk("busy_dd_count", 64'(dd_cnt - d0), 64'h1);
        chk("busy_dd_time", 64'(dd_cyc), 64'(t0 + 1));
        chk("busy_next_issue", 64'(first_after - dd_cyc), 64'h1);

        // Abort in DRAIN with three queued ops and a simultaneous push
        d0 = dd_cnt;
        busy_in = 1'b1;
        push(64'h0000_0000_0000_0002, 1'b1);
        for (int i = 0; i < 3; i++) push(ld[i], 1'b0);
        step();
        wait_cyc(st_cyc + NUM_PE + 3 + 3);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = ld[3];
        abort = 1'b1;
        step();
        abort = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = '0;
        flush_cnt++;
        chk("abort_op_zero", op_out, 64'h0);
        chk("abort_ready", 64'(cif.cmd_ready), 64'h1);
        chk("abort_no_dd_now", 64'(drain_done), 64'h0);
        busy_in = 1'b0;
        #1;
        chk("abort_idle", 64'(ring_idle), 64'h1);
        repeat (20) step();
        chk("abort_no_dd", 64'(dd_cnt - d0), 64'h0);
        chk("abort_idle_after", 64'(ring_idle), 64'h1);

        // Asynchronous reset while STEADY sits on op_out, LD queued
        d0 = dd_cnt;
        push(64'h0000_0000_0000_0002, 1'b1);
        push(ld[4], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_op_out", op_out, 64'h0);
        chk("mid_rst_ready", 64'(cif.cmd_ready), 64'h1);
        chk("mid_rst_drain_done", 64'(drain_done), 64'h0);
        chk("mid_rst_idle", 64'(ring_idle), 64'h1);
        exp_q.delete();
        flush_cnt++;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (30) step();
        chk("mid_rst_no_dd", 64'(dd_cnt - d0), 64'h0);
        chk("mid_rst_idle_after", 64'(ring_idle), 64'h1);

        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
